// File: rtl/apb_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_pkg
// Description : Shared types and constants for the APB command master. This
//               includes the FSM state encoding, the queued command record,
//               and the register map of the operand/result slave.
// Revision    : 1.0  initial release
// ============================================================================
package apb_cmd_pkg;

    // Storage widths of a queued command. The top zero-extends narrower
    // buses into these fields.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    // Register map of the operand/control/result slave
    localparam logic [31:0] ADDR_OP_A   = 32'h0;
    localparam logic [31:0] ADDR_OP_B   = 32'h4;
    localparam logic [31:0] ADDR_CTRL   = 32'h8;
    localparam logic [31:0] ADDR_RESULT = 32'hC;

    // Control register operation encodings
    localparam logic [31:0] CTRL_AND = 32'd1;
    localparam logic [31:0] CTRL_OR  = 32'd2;
    localparam logic [31:0] CTRL_XOR = 32'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_fifo
// Description : Synchronous command FIFO. Pointers carry one extra wrap bit
//               that distinguishes full from empty. The head entry is
//               presented combinationally.
// Revision    : 1.0  initial release
// ============================================================================
module apb_cmd_fifo
    import apb_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  apb_cmd_t i_cmd,
    input  logic     i_pop,
    output apb_cmd_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_ptr_one = (c_ptr_w + 1)'(1);

    apb_cmd_t           mem_q [DEPTH];
    logic [c_ptr_w:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w:0]   rd_ptr_q, rd_ptr_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                       (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = mem_q[rd_ptr_q[c_ptr_w-1:0]];

    // Next pointer values: each pointer advances only on an accepted operation
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage. The payload is not reset because validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[c_ptr_w-1:0]] <= i_cmd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_master
// Description : Converts a valid/ready command stream into APB3 transfers,
//               one at a time. It returns an in-order valid/ready response
//               stream carrying read data and an error flag from PSLVERR or
//               a PREADY timeout.
// Revision    : 1.0  initial release
// ============================================================================
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // The counter width also covers TIMEOUT=1, where the last count is 0
    localparam int                 c_cnt_w    = $clog2(TIMEOUT) + 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    apb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [c_cnt_w-1:0]  tmo_cnt_q, tmo_cnt_d;

    apb_cmd_t            w_cmd_in;
    apb_cmd_t            w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;

    // Pack the incoming command into the storage record
    always_comb begin
        w_cmd_in       = '0;
        w_cmd_in.write = cmd_write;
        w_cmd_in.addr  = CMD_ADDR_W'(cmd_addr);
        w_cmd_in.wdata = CMD_DATA_W'(cmd_wdata);
    end

    apb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_cmd   (w_cmd_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Transfer sequencing: pop, setup, access with timeout, then hold the response
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmo_cnt_d   = tmo_cnt_q;
        w_pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    paddr_d  = ADDR_W'(w_head.addr);
                    pwrite_d = w_head.write;
                    pwdata_d = DATA_W'(w_head.wdata);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                tmo_cnt_d = tmo_cnt_q + c_cnt_one;
                if (PREADY) begin
                    // Read data is returned only for error-free reads
                    rsp_rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = RESP;
                end else if (tmo_cnt_q == c_tmo_last) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    tmo_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // PSEL and PENABLE are decoded from the state register, so they drop
    // as soon as reset asserts.
    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign cmd_ready = !w_full;
    assign busy      = (state_q != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cmd_master
// Description : Directed testbench for apb_cmd_master. It contains a
//               behavioural register slave (A, B, control, read-only
//               result), a response scoreboard, and an APB setup/access
//               ordering monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_apb_cmd_master;
    import apb_cmd_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    apb_cmd_master #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural register slave ----------------
    logic [31:0] s_a, s_b, s_ctrl;
    logic        stall;

    function automatic logic [31:0] slave_result(input logic [31:0] a, b, c);
        case (c)
            CTRL_AND: slave_result = a & b;
            CTRL_OR:  slave_result = a | b;
            CTRL_XOR: slave_result = a ^ b;
            default:  slave_result = 32'h0;
        endcase
    endfunction

    always_comb begin
        PREADY  = !stall;
        PSLVERR = PSEL && PENABLE && PWRITE && (PADDR == ADDR_RESULT);
        case (PADDR)
            ADDR_OP_A:   PRDATA = s_a;
            ADDR_OP_B:   PRDATA = s_b;
            ADDR_CTRL:   PRDATA = s_ctrl;
            ADDR_RESULT: PRDATA = slave_result(s_a, s_b, s_ctrl);
            default:     PRDATA = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
            case (PADDR)
                ADDR_OP_A: s_a    <= PWDATA;
                ADDR_OP_B: s_b    <= PWDATA;
                ADDR_CTRL: s_ctrl <= PWDATA;
                default:   ;
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // The response scoreboard compares each accepted response in order
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Every ACCESS cycle must follow a SETUP or ACCESS cycle at the same address
    logic        prev_psel;
    logic [31:0] prev_paddr;
    always @(negedge clk) begin
        if (!reset && PSEL && PENABLE) begin
            check("access_after_setup", {31'd0, prev_psel}, 32'd1);
            check("paddr_stable", PADDR, prev_paddr);
        end
        if (!reset && PSEL && !PENABLE) begin
            check("single_setup", {31'd0, prev_psel}, 32'd0);
        end
        prev_psel  <= PSEL;
        prev_paddr <= PADDR;
    end

    // Drive one command and wait, with a bound, until it is accepted
    task automatic send(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_e);
        int n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready) begin
            e.rdata = exp_rd;
            e.err   = exp_e;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0) && !busy}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   n;
        int   accepted;
        int   pen_cnt;
        exp_t e;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b1;
        stall     = 1'b0;
        s_a       = 32'h0;
        s_b       = 32'h0;
        s_ctrl    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_psel", {31'd0, PSEL}, 32'd0);
        check("rst_penable", {31'd0, PENABLE}, 32'd0);
        check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Test 1: first command with cycle-exact latency
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = ADDR_OP_A;
        cmd_wdata = 32'hAAAAAAAA;
        e.rdata = 32'h0; e.err = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;             // accept edge N
        cmd_valid = 1'b0;
        @(negedge clk);                 // cycle N+1
        check("lat_n1_psel", {31'd0, PSEL}, 32'd0);
        check("lat_n1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);                 // cycle N+2
        check("lat_n2_setup", {30'd0, PSEL, PENABLE}, 32'd2);
        check("lat_n2_paddr", PADDR, ADDR_OP_A);
        check("lat_n2_pwdata", PWDATA, 32'hAAAAAAAA);
        @(negedge clk);                 // cycle N+3
        check("lat_n3_access", {30'd0, PSEL, PENABLE}, 32'd3);
        @(negedge clk);                 // cycle N+4
        check("lat_n4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        send(1'b1, ADDR_OP_B, 32'h0F0F0F0F, 32'h0, 1'b0);
        send(1'b1, ADDR_CTRL, CTRL_AND, 32'h0, 1'b0);
        send(1'b0, ADDR_RESULT, 32'h0, 32'h0A0A0A0A, 1'b0);
        wait_drain();

        // Test 2: OR and XOR results
        send(1'b1, ADDR_CTRL, CTRL_OR, 32'h0, 1'b0);
        send(1'b0, ADDR_RESULT, 32'h0, 32'hAFAFAFAF, 1'b0);
        send(1'b1, ADDR_CTRL, CTRL_XOR, 32'h0, 1'b0);
        send(1'b0, ADDR_RESULT, 32'h0, 32'hA5A5A5A5, 1'b0);
        wait_drain();

        // Test 3: write to the read-only register is flagged by the slave
        send(1'b1, ADDR_RESULT, 32'hDEADBEEF, 32'h0, 1'b1);
        send(1'b0, ADDR_RESULT, 32'h0, 32'hA5A5A5A5, 1'b0);
        wait_drain();

        // Test 4: back-pressure on responses fills the FIFO
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            case (i)
                0: begin cmd_write = 1'b1; cmd_addr = ADDR_OP_A; cmd_wdata = 32'h11111111; e.rdata = 32'h0;        end
                1: begin cmd_write = 1'b0; cmd_addr = ADDR_OP_A; cmd_wdata = 32'h0;        e.rdata = 32'h11111111; end
                2: begin cmd_write = 1'b1; cmd_addr = ADDR_OP_B; cmd_wdata = 32'h22222222; e.rdata = 32'h0;        end
                3: begin cmd_write = 1'b0; cmd_addr = ADDR_OP_B; cmd_wdata = 32'h0;        e.rdata = 32'h22222222; end
                default: begin cmd_write = 1'b1; cmd_addr = ADDR_CTRL; cmd_wdata = CTRL_OR; e.rdata = 32'h0;       end
            endcase
            e.err = 1'b0;
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back(e);
                accepted++;
            end else begin
                cmd_valid = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_accepted", accepted, 32'd5);
        @(negedge clk);
        check("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            check("bp_rdata_hold", rsp_rdata, 32'h0);
            check("bp_psel_low", {31'd0, PSEL}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(1'b0, ADDR_RESULT, 32'h0, 32'h33333333, 1'b0);
        wait_drain();

        // Test 5: PREADY stuck low triggers the timeout
        stall = 1'b1;
        send(1'b0, ADDR_OP_B, 32'h0, 32'h0, 1'b1);
        pen_cnt = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            if (PENABLE) pen_cnt++;
            @(negedge clk);
            n++;
        end
        check("tmo_penable_cycles", pen_cnt, 32'd16);
        check("tmo_psel_low", {31'd0, PSEL}, 32'd0);
        stall = 1'b0;
        send(1'b0, ADDR_OP_B, 32'h0, 32'h22222222, 1'b0);
        wait_drain();

        // Test 6: reset during ACCESS with two commands queued
        stall = 1'b1;
        send(1'b0, ADDR_CTRL, 32'h0, 32'h0, 1'b1);
        send(1'b0, ADDR_OP_A, 32'h0, 32'h0, 1'b0);
        send(1'b0, ADDR_OP_B, 32'h0, 32'h0, 1'b0);
        n = 0;
        while (!PENABLE && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst6_in_access", {31'd0, PENABLE}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst6_psel", {31'd0, PSEL}, 32'd0);
        check("rst6_penable", {31'd0, PENABLE}, 32'd0);
        check("rst6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst6_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst6_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst6_after_busy", {31'd0, busy}, 32'd0);
        send(1'b0, ADDR_OP_A, 32'h0, 32'h11111111, 1'b0);
        wait_drain();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
